ldpc_concat_nway: RTL and testbench

Parametrised N-channel frame concatenator for the LDPC encoder datapath. It is the successor to the fixed three-channel concatenator. It takes NUM_CH wide input streams and serialises a run-time-programmed number of OUT_WIDTH words from each enabled channel, in channel-index order, onto one narrow output stream, and marks the last word of each frame. Upstream buffering (EBR FIFOs) and downstream buffering sit outside this block.

---
 rtl/ldpc_concat_nway.sv | 209 ++++++++++++++++++++
 tb/tb_ldpc_concat_nway.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_concat_nway.sv
// ldpc_concat_nway
// N-channel frame concatenator for the LDPC encoder datapath. Each enabled
// channel with a non-zero length contributes exactly that many OUT_WIDTH words,
// unpacked LSB-first from its IN_WIDTH input words, in channel-index order.
// The last word of every frame is flagged with o_out_last.
//
// Ports
//   i_clock, i_reset   clock, synchronous active-high reset
//   i_in_data          NUM_CH packed input words, channel c at [c*IN_WIDTH +: IN_WIDTH]
//   i_in_valid         per-channel input valid
//   o_in_ready         per-channel input ready (one-hot or zero)
//   i_cfg_enable       channel enable mask
//   i_cfg_length       per-channel segment length in output words, [c*LEN_W +: LEN_W]
//   o_out_data         output word
//   o_out_valid        output valid
//   i_out_ready        output ready
//   o_out_last         final word of the frame
//   o_out_channel      source channel of o_out_data
//   o_busy             state is not ST_IDLE
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no frame; shadow config tracks live config every cycle
// ST_LOAD   | waiting for an input word from channel ch
// ST_UNPACK | presenting store[OUT_WIDTH-1:0] as the output word
module ldpc_concat_nway #(
   parameter int NUM_CH    = 3,
   parameter int OUT_WIDTH = 8,
   parameter int IN_WIDTH  = 96,
   parameter int LEN_W     = 10
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic [NUM_CH*IN_WIDTH-1:0]   i_in_data,
   input  logic [NUM_CH-1:0]            i_in_valid,
   output logic [NUM_CH-1:0]            o_in_ready,
   input  logic [NUM_CH-1:0]            i_cfg_enable,
   input  logic [NUM_CH*LEN_W-1:0]      i_cfg_length,
   output logic [OUT_WIDTH-1:0]         o_out_data,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic                         o_out_last,
   output logic [$clog2(NUM_CH)-1:0]    o_out_channel,
   output logic                         o_busy
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int SUB_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int CH_W  = $clog2(NUM_CH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_UNPACK = 2'd2
   } state_t;

   state_t                   state, state_d;
   logic [CH_W-1:0]          ch, ch_d;
   logic [LEN_W-1:0]         rem, rem_d;
   logic [SUB_W-1:0]         sub, sub_d;
   logic [IN_WIDTH-1:0]      store, store_d;
   logic [NUM_CH-1:0]        en_q, en_d;
   logic [NUM_CH*LEN_W-1:0]  len_q, len_d;
   logic                     valid_q, valid_d;
   logic                     last_q, last_d;

   logic [NUM_CH-1:0]        act_live, act_q, act_d;
   logic [CH_W:0]            first_live, next_hi, next_hi_d;
   logic [IN_WIDTH-1:0]      cur_word;
   logic [NUM_CH-1:0]        in_ready;

   function automatic logic [NUM_CH-1:0] active_mask(input logic [NUM_CH-1:0]       en,
                                                     input logic [NUM_CH*LEN_W-1:0] len);
      logic [NUM_CH-1:0] m;
      m = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m[c] = en[c] && (len[c*LEN_W +: LEN_W] != '0);
      end
      return m;
   endfunction

   // Lowest active channel with index >= floor, returned as {found, index}.
   function automatic logic [CH_W:0] pick_from(input logic [NUM_CH-1:0] act, input int floor);
      logic [CH_W:0] r;
      r = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (act[c] && c >= floor) r = {1'b1, CH_W'(c)};
      end
      return r;
   endfunction

   function automatic logic [LEN_W-1:0] len_of(input logic [NUM_CH*LEN_W-1:0] len,
                                                input logic [CH_W-1:0]         idx);
      return len[int'(idx)*LEN_W +: LEN_W];
   endfunction

   always_comb begin
      state_d  = state;
      ch_d     = ch;
      rem_d    = rem;
      sub_d    = sub;
      store_d  = store;
      en_d     = en_q;
      len_d    = len_q;
      in_ready = '0;

      act_live   = active_mask(i_cfg_enable, i_cfg_length);
      act_q      = active_mask(en_q, len_q);
      first_live = pick_from(act_live, 0);
      next_hi    = pick_from(act_q, int'(ch) + 1);
      cur_word   = i_in_data[int'(ch)*IN_WIDTH +: IN_WIDTH];

      case (state)
         ST_IDLE: begin
            en_d  = i_cfg_enable;
            len_d = i_cfg_length;
            if (first_live[CH_W]) begin
               ch_d    = first_live[CH_W-1:0];
               rem_d   = len_of(i_cfg_length, first_live[CH_W-1:0]);
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            in_ready[ch] = 1'b1;
            if (i_in_valid[ch]) begin
               store_d = cur_word;
               sub_d   = '0;
               state_d = ST_UNPACK;
            end
         end

         ST_UNPACK: begin
            if (i_out_ready) begin
               store_d = store >> OUT_WIDTH;
               sub_d   = (sub == SUB_W'(RATIO - 1)) ? '0 : sub + 1'b1;
               rem_d   = rem - 1'b1;
               if (rem == LEN_W'(1)) begin
                  // Segment done: leftover sub-words in store are dropped.
                  if (next_hi[CH_W]) begin
                     ch_d    = next_hi[CH_W-1:0];
                     rem_d   = len_of(len_q, next_hi[CH_W-1:0]);
                     state_d = ST_LOAD;
                  end else begin
                     // Frame done: the next frame is defined by config right now.
                     en_d  = i_cfg_enable;
                     len_d = i_cfg_length;
                     if (first_live[CH_W]) begin
                        ch_d    = first_live[CH_W-1:0];
                        rem_d   = len_of(i_cfg_length, first_live[CH_W-1:0]);
                        state_d = ST_LOAD;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               end else if (sub == SUB_W'(RATIO - 1)) begin
                  // Chained load: take the next word in the same cycle to avoid a bubble.
                  in_ready[ch] = 1'b1;
                  if (i_in_valid[ch]) begin
                     store_d = cur_word;
                  end else begin
                     state_d = ST_LOAD;
                  end
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Registered flags describe the word that will be presented next cycle.
      act_d     = active_mask(en_d, len_d);
      next_hi_d = pick_from(act_d, int'(ch_d) + 1);
      valid_d   = (state_d == ST_UNPACK);
      last_d    = (state_d == ST_UNPACK) && (rem_d == LEN_W'(1)) && !next_hi_d[CH_W];
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state   <= ST_IDLE;
         ch      <= '0;
         rem     <= '0;
         sub     <= '0;
         store   <= '0;
         en_q    <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state   <= state_d;
         ch      <= ch_d;
         rem     <= rem_d;
         sub     <= sub_d;
         store   <= store_d;
         en_q    <= en_d;
         len_q   <= len_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign o_in_ready    = in_ready;
   assign o_out_data    = store[OUT_WIDTH-1:0];
   assign o_out_valid   = valid_q;
   assign o_out_last    = last_q;
   assign o_out_channel = ch;
   assign o_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_ldpc_concat_nway.sv
// Testbench for ldpc_concat_nway at default parameters (3 ch, 96 -> 8 bits).
// Input byte j of word k on channel c is 8'(c*80 + k*12 + j); the bench model
// predicts every output word from the frame configuration alone.
module tb_ldpc_concat_nway;

   localparam int NUM_CH = 3;
   localparam int OUT_W  = 8;
   localparam int IN_W   = 96;
   localparam int LEN_W  = 10;
   localparam int RATIO  = IN_W / OUT_W;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_CH*IN_W-1:0]    in_data;
   logic [NUM_CH-1:0]         in_valid;
   logic [NUM_CH-1:0]         in_ready;
   logic [NUM_CH-1:0]         cfg_en;
   logic [NUM_CH*LEN_W-1:0]   cfg_len;
   logic [OUT_W-1:0]          out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic                      out_last;
   logic [1:0]                out_ch;
   logic                      busy;

   always #5 clk = ~clk;

   ldpc_concat_nway #(.NUM_CH(NUM_CH), .OUT_WIDTH(OUT_W), .IN_WIDTH(IN_W), .LEN_W(LEN_W)) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_in_data     (in_data),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_cfg_enable  (cfg_en),
      .i_cfg_length  (cfg_len),
      .o_out_data    (out_data),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_out_last    (out_last),
      .o_out_channel (out_ch),
      .o_busy        (busy)
   );

   typedef struct {
      logic [2:0]  en;
      logic [29:0] len;
      logic [2:0]  en2;
      logic [29:0] len2;
      bit          rnd;
      int          exp_words;
      int          exp_last_ch;
      int          exp_cycles;
   } vec_t;

   typedef struct {
      int ch;
      int data;
      bit last;
   } exp_t;

   vec_t  vecs[12];
   exp_t  exp_q[$];
   int    k[NUM_CH];
   int    kb[NUM_CH];
   int    n_vec = 0;
   int    n_err = 0;
   bit    rnd_mode;
   bit    prev_stall;
   logic [11:0] prev_snap;
   int    n_words, cyc, last_ch_seen;
   bit    seen_valid, bad_onehot, bad_skip;
   logic [2:0] inactive;

   task automatic check(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] en, input int l0, input int l1, input int l2,
                               input logic [2:0] en2, input int m0, input int m1, input int m2,
                               input bit rnd, input int w, input int lc, input int cy);
      vec_t v;
      v.en          = en;
      v.len         = {10'(l2), 10'(l1), 10'(l0)};
      v.en2         = en2;
      v.len2        = {10'(m2), 10'(m1), 10'(m0)};
      v.rnd         = rnd;
      v.exp_words   = w;
      v.exp_last_ch = lc;
      v.exp_cycles  = cy;
      return v;
   endfunction

   function automatic logic [2:0] act_of(input logic [2:0] en, input logic [29:0] len);
      logic [2:0] m;
      for (int c = 0; c < NUM_CH; c++) m[c] = en[c] && (len[c*LEN_W +: LEN_W] != 0);
      return m;
   endfunction

   task automatic model_frame(input logic [2:0] en, input logic [29:0] len);
      logic [2:0] act;
      int         hi, l;
      exp_t       e;
      act = act_of(en, len);
      hi  = -1;
      for (int c = 0; c < NUM_CH; c++) if (act[c]) hi = c;
      for (int c = 0; c < NUM_CH; c++) begin
         if (act[c]) begin
            l = int'(len[c*LEN_W +: LEN_W]);
            for (int i = 0; i < l; i++) begin
               e.ch   = c;
               e.data = int'(8'(c*80 + (kb[c] + i/RATIO)*RATIO + i%RATIO));
               e.last = (c == hi) && (i == l - 1);
               exp_q.push_back(e);
            end
            kb[c] += (l + RATIO - 1) / RATIO;
         end
      end
   endtask

   task automatic step();
      bit   acc_out;
      logic [NUM_CH-1:0] acc_in;
      exp_t e;
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
         in_valid[c] = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int j = 0; j < RATIO; j++) in_data[c*IN_W + j*OUT_W +: OUT_W] = 8'(c*80 + k[c]*RATIO + j);
      end
      out_ready = rnd_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
      #1;
      if (prev_stall) check("stall_hold", {out_valid, out_last, out_ch, out_data}, prev_snap);
      if (!$onehot0(in_ready)) bad_onehot = 1'b1;
      if ((in_ready & inactive) != 0) bad_skip = 1'b1;
      if (out_valid) seen_valid = 1'b1;
      if (seen_valid && exp_q.size() > 0) cyc++;
      acc_out = out_valid && out_ready;
      acc_in  = in_ready & in_valid;
      if (acc_out) begin
         n_words++;
         last_ch_seen = int'(out_ch);
         if (exp_q.size() == 0) begin
            check("extra_word", {out_ch, out_last, out_data}, 0);
         end else begin
            e = exp_q.pop_front();
            check("word", {out_ch, out_last, out_data}, {2'(e.ch), e.last, 8'(e.data)});
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_snap  = {out_valid, out_last, out_ch, out_data};
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) if (acc_in[c]) k[c]++;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   words1, steps, phase;
      v = vecs[idx];
      rnd_mode = v.rnd;
      cfg_en   = v.en;
      cfg_len  = v.len;
      inactive = ~(act_of(v.en, v.len) | act_of(v.en2, v.len2));
      model_frame(v.en, v.len);
      words1 = exp_q.size();
      model_frame(v.en2, v.len2);
      n_words = 0; cyc = 0; seen_valid = 0; bad_onehot = 0; bad_skip = 0; last_ch_seen = -1;
      steps = 0; phase = 0;
      do begin
         step();
         steps++;
         if (phase == 0) begin
            cfg_en  = v.en2;
            cfg_len = v.len2;
            phase   = 1;
         end
         if (phase == 1 && n_words >= words1) begin
            cfg_en  = 3'b000;
            cfg_len = {10'd9, 10'd9, 10'd9};
            phase   = 2;
         end
      end while ((exp_q.size() > 0 || steps < 4) && steps < 4000);
      check($sformatf("v%0d_left", idx), exp_q.size(), 0);
      exp_q.delete();
      check($sformatf("v%0d_words", idx), n_words, v.exp_words);
      if (v.exp_words > 0) check($sformatf("v%0d_last_ch", idx), last_ch_seen, v.exp_last_ch);
      if (v.exp_cycles > 0) check($sformatf("v%0d_cycles", idx), cyc, v.exp_cycles);
      check($sformatf("v%0d_idle_busy", idx), busy, 0);
      check($sformatf("v%0d_ready_onehot", idx), bad_onehot, 0);
      check($sformatf("v%0d_skip_ready", idx), bad_skip, 0);
   endtask

   initial begin
      //          en      len0 len1 len2  en2     m0 m1 m2 rnd words lastch cycles
      vecs[0]  = mk(3'b111, 144, 12, 132, 3'b000, 7, 7, 7, 0, 288, 2, 290);
      vecs[1]  = mk(3'b111,  12,  5,  20, 3'b000, 7, 7, 7, 0,  37, 2,  39);
      vecs[2]  = mk(3'b101,   4,  9,   7, 3'b000, 7, 7, 7, 0,  11, 2,  12);
      vecs[3]  = mk(3'b111,   4,  0,   7, 3'b000, 7, 7, 7, 0,  11, 2,  12);
      vecs[4]  = mk(3'b011,   1,  1,  50, 3'b000, 7, 7, 7, 0,   2, 1,   3);
      vecs[5]  = mk(3'b110,  30, 25,  13, 3'b000, 7, 7, 7, 1,  38, 2,   0);
      vecs[6]  = mk(3'b111,  13, 24,   1, 3'b000, 7, 7, 7, 1,  38, 2,   0);
      vecs[7]  = mk(3'b000,   5,  5,   5, 3'b000, 7, 7, 7, 0,   0, 0,   0);
      vecs[8]  = mk(3'b100,   0,  0, 300, 3'b000, 7, 7, 7, 0, 300, 2, 300);
      vecs[9]  = mk(3'b111,   3,  4,   5, 3'b011, 2, 13, 0, 0,  27, 1,  31);
      vecs[10] = mk(3'b111,   1,  1,   1, 3'b000, 7, 7, 7, 1,   3, 2,   0);
      vecs[11] = mk(3'b111,   2,  3,   4, 3'b000, 7, 7, 7, 0,   9, 0,  11);
      vecs[11].exp_last_ch = 2;

      rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
      cfg_en = '0; cfg_len = '0; rnd_mode = 0; prev_stall = 0; inactive = '0;
      bad_onehot = 0; bad_skip = 0; seen_valid = 0; n_words = 0; cyc = 0;
      for (int c = 0; c < NUM_CH; c++) begin k[c] = 0; kb[c] = 0; end
      @(posedge clk); #1;
      step();
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_data", out_data, 0);
      check("rst_channel", out_ch, 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) run_vec(i);

      // Reset in the middle of ST_UNPACK, then a clean frame.
      rnd_mode = 0; inactive = '0;
      cfg_en = 3'b111; cfg_len = {10'd20, 10'd20, 10'd20};
      model_frame(cfg_en, cfg_len);
      step();
      cfg_en = 3'b000;
      for (int i = 0; i < 7; i++) step();
      check("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      step();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_last", out_last, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_channel", out_ch, 0);
      exp_q.delete();
      for (int c = 0; c < NUM_CH; c++) kb[c] = k[c];
      prev_stall = 0;
      rst = 1'b0;
      run_vec(11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
